// File: rtl/d_cmp_hazard_ctrl_pkg.sv
// Shared encodings for the D-stage compare hazard/forwarding controller:
// forwarding mux selects plus the Tnew/Tuse constants the decoder emits.
package d_cmp_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_W   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_E   = 2'd3;

  localparam logic [1:0] TNEW_IMM  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] TUSE_CMP   = 2'd0;
  localparam logic [1:0] TUSE_ALU   = 2'd1;
  localparam logic [1:0] TUSE_STORE = 2'd2;

endpackage

// File: rtl/d_cmp_hazard_ctrl_fwd_pick.sv
// Per-operand hazard decision: compares one D-stage source register against
// the E/M/W write records and returns its stall request and forward select.
module d_fwd_pick
  import d_cmp_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [TNEW_W-1:0] tuse,
  input  logic [ADDR_W-1:0] e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [ADDR_W-1:0] m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic [ADDR_W-1:0] w_wa,
  output logic              stall,
  output logic [1:0]        fwd_sel
);

  always_comb begin
    stall   = 1'b0;
    fwd_sel = FWD_GRF;
    if (addr != '0) begin
      stall = ((e_wa == addr) && (e_tnew > tuse)) ||
              ((m_wa == addr) && (m_tnew > tuse));
      // Youngest matching writer wins; if it is not ready yet, fall back to
      // the GRF path and let the stall cover the wait.
      if (e_wa == addr)
        fwd_sel = (e_tnew == '0) ? FWD_E : FWD_GRF;
      else if (m_wa == addr)
        fwd_sel = (m_tnew == '0) ? FWD_M : FWD_GRF;
      else if (w_wa == addr)
        fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/d_cmp_hazard_ctrl.sv
// Hazard and forwarding controller for the D-stage branch comparator:
// Tnew scoreboard over E/M/W, stall generation and a saturating stall counter.
module d_cmp_hazard_ctrl
  import d_cmp_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] D_rs,
  input  logic [ADDR_W-1:0] D_rt,
  input  logic [TNEW_W-1:0] D_tuse_rs,
  input  logic [TNEW_W-1:0] D_tuse_rt,
  input  logic [ADDR_W-1:0] D_wa,
  input  logic [TNEW_W-1:0] D_tnew,
  output logic              D_stall,
  output logic [1:0]        D_fwd_rs,
  output logic [1:0]        D_fwd_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [ADDR_W-1:0] e_wa, m_wa, w_wa;
  logic [TNEW_W-1:0] e_tnew, m_tnew;
  logic              stall_rs, stall_rt;

  // W's Tnew is always zero after two decrements, so only its address is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa      <= '0;
      e_tnew    <= '0;
      m_wa      <= '0;
      m_tnew    <= '0;
      w_wa      <= '0;
      stall_cnt <= '0;
    end else begin
      w_wa   <= m_wa;
      m_wa   <= e_wa;
      m_tnew <= sat_dec(e_tnew);
      e_wa   <= D_stall ? '0 : D_wa;
      e_tnew <= D_stall ? '0 : D_tnew;
      if (D_stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  d_fwd_pick #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_pick_rs (
    .addr    (D_rs),
    .tuse    (D_tuse_rs),
    .e_wa    (e_wa),
    .e_tnew  (e_tnew),
    .m_wa    (m_wa),
    .m_tnew  (m_tnew),
    .w_wa    (w_wa),
    .stall   (stall_rs),
    .fwd_sel (D_fwd_rs)
  );

  d_fwd_pick #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_pick_rt (
    .addr    (D_rt),
    .tuse    (D_tuse_rt),
    .e_wa    (e_wa),
    .e_tnew  (e_tnew),
    .m_wa    (m_wa),
    .m_tnew  (m_tnew),
    .w_wa    (w_wa),
    .stall   (stall_rt),
    .fwd_sel (D_fwd_rt)
  );

  assign D_stall = stall_rs | stall_rt;

endmodule
